// File: rtl/fifo_pack_pkg.sv
// Shared constants and pointer helpers for the packed-read FIFO.
// Depth 4, 64-bit entries, 3-bit pointers (2-bit index plus wrap bit).
package fifo_pack_pkg;

    localparam int FIFO_PACK_DEPTH = 4;
    localparam int FIFO_PACK_DW    = 64;
    localparam int FIFO_PACK_PW    = 3;
    localparam int FIFO_PACK_AW    = 2;

    typedef logic [FIFO_PACK_PW-1:0] ptr_t;
    typedef logic [FIFO_PACK_AW-1:0] idx_t;
    typedef logic [FIFO_PACK_DW-1:0] data_t;

    function automatic idx_t ptr_idx(input ptr_t p);
        return p[FIFO_PACK_AW-1:0];
    endfunction

endpackage

// File: rtl/fifo_pack_mem.sv
// 4x64 register file: one write port, two combinational read ports.
// Contents are intentionally not reset.
module fifo_pack_mem
    import fifo_pack_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  idx_t  waddr_i,
    input  data_t wdata_i,
    input  idx_t  raddr0_i,
    input  idx_t  raddr1_i,
    output data_t rdata0_o,
    output data_t rdata1_o
);

    data_t mem_q [FIFO_PACK_DEPTH];

    // Store the write data into the addressed entry.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fifo_pack.sv
// 4-entry FIFO with single or double (packed 128-bit) pops.
// Define HWPE_FIFO_PACK_CNT_EN to expose the occupancy count on cnt.
module fifo_pack
    import fifo_pack_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [FIFO_PACK_DW-1:0]  wd,
    output logic                     full,
    input  logic                     ren,
    input  logic                     r2entry,
    output logic [2*FIFO_PACK_DW-1:0] rd,
    output logic                     empty,
    output logic                     avail2
`ifdef HWPE_FIFO_PACK_CNT_EN
    ,
    output logic [FIFO_PACK_PW-1:0]  cnt
`endif
);

    ptr_t  wp_q, wp_d;
    ptr_t  rp_q, rp_d;
    ptr_t  count;
    ptr_t  rp_nxt;
    logic  pop1, pop2, rd_acc, wr_acc;
    data_t rdata0, rdata1;

    assign count  = wp_q - rp_q;
    assign full   = (count == ptr_t'(FIFO_PACK_DEPTH));
    assign empty  = (count == '0);
    assign avail2 = (count >= ptr_t'(2));
    assign rp_nxt = rp_q + ptr_t'(1);

`ifdef HWPE_FIFO_PACK_CNT_EN
    assign cnt = count;
`endif

    // A double pop needs two entries; otherwise it acts as no read at all.
    always_comb begin
        pop1   = ren & ~r2entry & ~empty;
        pop2   = ren & r2entry & avail2;
        rd_acc = pop1 | pop2;
        wr_acc = wen & (~full | rd_acc);
        wp_d   = wp_q + ptr_t'(wr_acc);
        rp_d   = rp_q;
        if (pop2) begin
            rp_d = rp_q + ptr_t'(2);
        end else if (pop1) begin
            rp_d = rp_nxt;
        end
    end

    // Pointer registers; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    fifo_pack_mem u_mem (
        .clk      (clk),
        .we_i     (wr_acc & ~rst),
        .waddr_i  (ptr_idx(wp_q)),
        .wdata_i  (wd),
        .raddr0_i (ptr_idx(rp_q)),
        .raddr1_i (ptr_idx(rp_nxt)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // Zero-latency output; unheld lanes read as zero.
    always_comb begin
        rd = '0;
        if (!empty) begin
            rd[FIFO_PACK_DW-1:0] = rdata0;
        end
        if (avail2) begin
            rd[2*FIFO_PACK_DW-1:FIFO_PACK_DW] = rdata1;
        end
    end

endmodule

// File: tb/tb_fifo_pack.sv
// Directed self-checking bench for fifo_pack.
// Optional cnt port checked when HWPE_FIFO_PACK_CNT_EN is defined.
module tb_fifo_pack;

    logic         clk = 1'b0;
    logic         rst;
    logic         wen;
    logic [63:0]  wd;
    logic         full;
    logic         ren;
    logic         r2entry;
    logic [127:0] rd;
    logic         empty;
    logic         avail2;
`ifdef HWPE_FIFO_PACK_CNT_EN
    logic [2:0]   cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_pack dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .wd      (wd),
        .full    (full),
        .ren     (ren),
        .r2entry (r2entry),
        .rd      (rd),
        .empty   (empty),
        .avail2  (avail2)
`ifdef HWPE_FIFO_PACK_CNT_EN
        ,
        .cnt     (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic w, input logic [63:0] d,
                        input logic r, input logic r2);
        wen = w; wd = d; ren = r; r2entry = r2;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; r2entry = 1'b0; wd = '0;
    endtask

    task automatic test_reset();
        step(1'b1, 64'h77, 1'b0, 1'b0);
        step(1'b1, 64'h78, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 64'h99, 1'b1, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty got %b want 1", empty);
        end
        n_checks++;
        if (full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full got %b want 0", full);
        end
        n_checks++;
        if (avail2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_avail2 got %b want 0", avail2);
        end
        n_checks++;
        if (rd !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rd got %h want 0", rd);
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0]  exp_full;
        logic [63:0] v;
        exp_full = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            v = 64'hA0 + 64'(i);
            step(1'b1, v, 1'b0, 1'b0);
            n_checks++;
            if (full !== exp_full[i]) begin
                n_fail++;
                $display("FAIL fill_full[%0d] got %b want %b", i, full, exp_full[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            v = 64'hA0 + 64'(i);
            n_checks++;
            if (rd[63:0] !== v) begin
                n_fail++;
                $display("FAIL drain_rd[%0d] got %h want %h", i, rd[63:0], v);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty got %b want 1", empty);
        end
    endtask

    task automatic test_double();
        step(1'b1, 64'h11, 1'b0, 1'b0);
        step(1'b1, 64'h22, 1'b0, 1'b0);
        step(1'b1, 64'h33, 1'b0, 1'b0);
        n_checks++;
        if (rd !== {64'h22, 64'h11} || avail2 !== 1'b1) begin
            n_fail++;
            $display("FAIL double_pre got rd=%h av2=%b want 22_11 av2=1", rd, avail2);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (rd[63:0] !== 64'h33) begin
            n_fail++;
            $display("FAIL double_lo got %h want 33", rd[63:0]);
        end
        n_checks++;
        if (rd[127:64] !== 64'h0 || avail2 !== 1'b0) begin
            n_fail++;
            $display("FAIL double_hi got %h av2=%b want 0 av2=0", rd[127:64], avail2);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL double_empty got %b want 1", empty);
        end
    endtask

    task automatic test_reject_double();
        step(1'b1, 64'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (empty !== 1'b0 || avail2 !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_flags got e=%b a2=%b f=%b want 0 0 0", empty, avail2, full);
        end
        n_checks++;
        if (rd !== {64'h0, 64'h55}) begin
            n_fail++;
            $display("FAIL rej_rd got %h want 0_55", rd);
        end
`ifdef HWPE_FIFO_PACK_CNT_EN
        n_checks++;
        if (cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL rej_cnt got %0d want 1", cnt);
        end
`endif
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_full_ops();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
        end
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL fullops_full got %b want 1", full);
        end
        step(1'b1, 64'hB4, 1'b1, 1'b1);
        n_checks++;
        if (rd !== {64'hB3, 64'hB2} || full !== 1'b0 || avail2 !== 1'b1) begin
            n_fail++;
            $display("FAIL fullops_wr_rd2 got rd=%h f=%b a2=%b want B3_B2 0 1", rd, full, avail2);
        end
`ifdef HWPE_FIFO_PACK_CNT_EN
        n_checks++;
        if (cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL fullops_cnt got %0d want 3", cnt);
        end
`endif
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (rd !== {64'h0, 64'hB4}) begin
            n_fail++;
            $display("FAIL fullops_b4 got %h want 0_B4", rd);
        end
        step(1'b1, 64'hC0, 1'b0, 1'b0);
        step(1'b1, 64'hC1, 1'b0, 1'b0);
        step(1'b1, 64'hC2, 1'b0, 1'b0);
        step(1'b1, 64'hD0, 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || rd !== {64'hC0, 64'hB4}) begin
            n_fail++;
            $display("FAIL fullops_nowrite got rd=%h f=%b want C0_B4 1", rd, full);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (rd !== {64'hC2, 64'hC1}) begin
            n_fail++;
            $display("FAIL fullops_tail got %h want C2_C1", rd);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fullops_empty got %b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        logic [2:0]  ops [15];
        logic [63:0] q [$];
        logic [63:0] e0, e1, v;
        int          pops, k;
        logic        wacc;
        ops = '{3'b100, 3'b100, 3'b100, 3'b111, 3'b100,
                3'b100, 3'b110, 3'b011, 3'b100, 3'b010,
                3'b111, 3'b100, 3'b010, 3'b010, 3'b011};
        k = 0;
        for (int i = 0; i < 15; i++) begin
            e0 = (q.size() > 0) ? q[0] : 64'h0;
            e1 = (q.size() > 1) ? q[1] : 64'h0;
            n_checks++;
            if (rd !== {e1, e0}) begin
                n_fail++;
                $display("FAIL wrap_rd[%0d] got %h want %h_%h", i, rd, e1, e0);
            end
            n_checks++;
            if (empty !== (q.size() == 0) || full !== (q.size() == 4)
                || avail2 !== (q.size() >= 2)) begin
                n_fail++;
                $display("FAIL wrap_flags[%0d] got e=%b f=%b a2=%b size %0d",
                         i, empty, full, avail2, q.size());
            end
`ifdef HWPE_FIFO_PACK_CNT_EN
            n_checks++;
            if (int'(cnt) !== q.size()) begin
                n_fail++;
                $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, cnt, q.size());
            end
`endif
            pops = 0;
            if (ops[i][1] && !ops[i][0] && q.size() >= 1) pops = 1;
            if (ops[i][1] && ops[i][0] && q.size() >= 2) pops = 2;
            wacc = ops[i][2] && (q.size() < 4 || pops > 0);
            v = 64'h1000 + 64'(k);
            step(ops[i][2], v, ops[i][1], ops[i][0]);
            for (int p = 0; p < pops; p++) void'(q.pop_front());
            if (wacc) begin
                q.push_back(v);
                k++;
            end
        end
        n_checks++;
        if (k !== 10 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end got writes=%0d empty=%b want 10 1", k, empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        wen = 1'b0; wd = '0; ren = 1'b0; r2entry = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_double();
        test_reject_double();
        test_full_ops();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
